cim_tile_arbiter: RTL and testbench
===================================

Name: cim_tile_arbiter

Overview:
- Shares one CIM tile command port (write-enable, start, read address, ready) between NUM_REQ layer controllers, e.g. several conv layers time-multiplexed onto one crossbar.
- Round-robin grant; holds the grant for one complete load/compute job, from grant through start to CIM ready returning.
- Sits between the layers' control FSMs and the CIM tile interface.

Parameters:
- NUM_REQ, 4: number of requesting layers (2..16).
- ADDR_WIDTH, 4: width of the CIM/ibuf read address.
- IDX_WIDTH, $clog2(NUM_REQ): width of the grant index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- i_req  input  NUM_REQ  per-requester request; held high until the job completes.
- i_req_we  input  NUM_REQ  per-requester CIM write enable.
- i_req_start  input  NUM_REQ  per-requester CIM start pulse.
- i_req_addr  input  ADDR_WIDTH x NUM_REQ (unpacked [NUM_REQ-1:0])  per-requester CIM read address.
- o_gnt  output  NUM_REQ  one-hot grant, registered.
- o_req_cim_ready  output  NUM_REQ  i_cim_ready routed to the granted requester only; 0 for all others.
- o_gnt_idx  output  IDX_WIDTH  index of the current or last grant.
- o_busy  output  1  high in any state except IDLE.
- o_cim_we  output  1  write enable to the CIM tile.
- o_cim_start  output  1  start to the CIM tile.
- o_cim_rd_addr  output  ADDR_WIDTH  read address to the CIM tile.
- i_cim_ready  input  1  CIM tile ready; low while computing.

Behaviour:
- Reset values (asynchronous): state=IDLE, o_gnt=0, o_gnt_idx=NUM_REQ-1 (so requester 0 has first priority), o_busy=0. Because o_gnt=0, o_cim_we=0, o_cim_start=0, o_cim_rd_addr=0 and o_req_cim_ready=0.
- Reset mid-job drops the grant immediately. The CIM job is abandoned and no completion is reported.
- FSM states: IDLE, GRANT, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If any i_req is high, select the first requester with i_req high, searching upward from o_gnt_idx+1 modulo NUM_REQ.
  - Next cycle: o_gnt one-hot on that index, o_gnt_idx updated, state=GRANT.
  - Request-to-grant latency is 1 cycle.
  - If no i_req is high, remain in IDLE with o_gnt=0.
- GRANT:
  - Outputs follow the granted requester g combinationally: o_cim_we=i_req_we[g], o_cim_start=i_req_start[g], o_cim_rd_addr=i_req_addr[g].
  - If i_req_start[g]=1 and i_req[g]=1: go to WAIT_LOW.
  - Else if i_req[g]=0: release, i.e. o_gnt=0 and state=IDLE next cycle. If start and request drop arrive in the same cycle, the start is suppressed (o_cim_start=0).
- WAIT_LOW:
  - o_cim_we and o_cim_start forced to 0; o_cim_rd_addr still follows g.
  - Move to WAIT_HIGH on the first cycle i_cim_ready=0. This guards against a stale ready-high in the cycle right after start.
- WAIT_HIGH:
  - Same output gating as WAIT_LOW.
  - On i_cim_ready=1: state=IDLE and o_gnt=0 next cycle.
  - The requester sees completion via o_req_cim_ready[g]=1 in that cycle, then must drop i_req or re-request.
- Back-to-back jobs: minimum 1 IDLE cycle between grants.
  - A requester holding i_req high after completion is re-arbitrated fairly.
  - It is granted again only if no other requester is pending, or after all others have been served (round-robin).
- Ungranted requesters: their we, start and addr are ignored and their o_req_cim_ready is 0.
- o_gnt_idx keeps the last grant while in IDLE; it is the round-robin pointer.
- No combinational path from i_cim_ready to o_gnt. o_req_cim_ready is combinational from i_cim_ready gated by the registered grant.

Decomposition:
- Shared package cim_arb_pkg holds:
  - the state enum (IDLE, GRANT, WAIT_LOW, WAIT_HIGH);
  - a function rr_pick(req, last_idx) returning the next index and a valid bit.
- One sub-module, rr_arbiter: purely combinational round-robin priority select (req vector and last index in; one-hot grant and index out).
- FSM, muxing and gating stay in cim_tile_arbiter.

Test Plan:
- Single job, NUM_REQ=4: i_req=4'b0100 at cycle 0 → o_gnt=4'b0100 at cycle 1. Then req2 addr=5, start → o_cim_start=1 and o_cim_rd_addr=5 that cycle. Then ready 1→0→1 over 3 cycles → o_gnt=0 one cycle after ready rises; o_gnt_idx=2.
- Round-robin fairness: i_req=4'b1111 held, each job completed in 4 cycles → grant order 0,1,2,3,0 with exactly 1 IDLE cycle between grants.
- Isolation: req1 granted while req3 drives we=1, start=1, addr=9 → o_cim_we=0 and o_cim_start=0 from req3, o_cim_rd_addr follows req1, o_req_cim_ready[3]=0.
- Stale ready and gating: i_cim_ready stays 1 for 2 cycles after start → state remains WAIT_LOW and grant is held. Then ready 0, then 1 → release. During WAIT states, req we=1 → o_cim_we=0.
- Abort and simultaneous events:
  - In GRANT, i_req[g] and i_req_start[g] drop/rise in the same cycle → o_cim_start=0 and grant released next cycle.
  - In GRANT, i_req[g] drops without start → grant released next cycle.
- Async reset: assert rst mid-WAIT_HIGH between clock edges → o_gnt=0, o_busy=0, o_cim_* =0 immediately. After release, i_req=4'b1001 → requester 0 granted first.

Source files
------------

// File: rtl/cim_arb_pkg.sv
// Shared types for the CIM tile arbiter: FSM state encoding and the round-robin
// pick helper used by the combinational arbiter.
package cim_arb_pkg;

   localparam int unsigned MaxReq  = 16;
   localparam int unsigned MaxIdxW = 4;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StWaitLow,
      StWaitHigh
   } arb_state_e;

   typedef struct packed {
      logic               valid;
      logic [MaxIdxW-1:0] idx;
   } rr_pick_t;

   // First set request strictly after last_idx, wrapping modulo num_req.
   function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  req,
                                        input logic [MaxIdxW-1:0] last_idx,
                                        input int unsigned        num_req);
      rr_pick_t    pick;
      int unsigned cand;
      pick = '0;
      for (int unsigned off = 1; off <= MaxReq; off++) begin
         cand = ({28'd0, last_idx} + off) % num_req;
         if (off <= num_req && !pick.valid && req[cand[MaxIdxW-1:0]]) begin
            pick.valid = 1'b1;
            pick.idx   = cand[MaxIdxW-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: one-hot grant and index of the next requester
// after the last granted one.
module rr_arbiter
   import cim_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_WIDTH-1:0] last_idx,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [IDX_WIDTH-1:0] idx,
   output logic                 valid
);

   rr_pick_t pick;

   always_comb begin
      pick  = rr_pick(MaxReq'(req), MaxIdxW'(last_idx), NUM_REQ);
      valid = pick.valid;
      idx   = IDX_WIDTH'(pick.idx);
      gnt   = '0;
      if (pick.valid) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cim_tile_arbiter.sv
// Shares one CIM tile command port among NUM_REQ layer controllers, holding the
// round-robin grant for a whole start/compute/ready job.
module cim_tile_arbiter
   import cim_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    i_req,
   input  logic [NUM_REQ-1:0]    i_req_we,
   input  logic [NUM_REQ-1:0]    i_req_start,
   input  logic [ADDR_WIDTH-1:0] i_req_addr [NUM_REQ-1:0],
   output logic [NUM_REQ-1:0]    o_gnt,
   output logic [NUM_REQ-1:0]    o_req_cim_ready,
   output logic [IDX_WIDTH-1:0]  o_gnt_idx,
   output logic                  o_busy,
   output logic                  o_cim_we,
   output logic                  o_cim_start,
   output logic [ADDR_WIDTH-1:0] o_cim_rd_addr,
   input  logic                  i_cim_ready
);

   arb_state_e            state_q, state_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic [IDX_WIDTH-1:0]  gnt_idx_q, gnt_idx_d;
   logic [NUM_REQ-1:0]    pick_gnt;
   logic [IDX_WIDTH-1:0]  pick_idx;
   logic                  pick_valid;
   logic                  g_req, g_we, g_start;
   logic [ADDR_WIDTH-1:0] g_addr;

   rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_rr_arbiter (
      .req      (i_req),
      .last_idx (gnt_idx_q),
      .gnt      (pick_gnt),
      .idx      (pick_idx),
      .valid    (pick_valid)
   );

   assign g_req   = i_req[gnt_idx_q];
   assign g_we    = i_req_we[gnt_idx_q];
   assign g_start = i_req_start[gnt_idx_q];
   assign g_addr  = i_req_addr[gnt_idx_q];

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      gnt_idx_d     = gnt_idx_q;
      o_cim_we      = 1'b0;
      o_cim_start   = 1'b0;
      o_cim_rd_addr = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               gnt_d     = pick_gnt;
               gnt_idx_d = pick_idx;
               state_d   = StGrant;
            end
         end
         StGrant: begin
            o_cim_we      = g_we;
            // A start arriving with the request drop is an abort, not a job.
            o_cim_start   = g_start & g_req;
            o_cim_rd_addr = g_addr;
            if (g_req && g_start) begin
               state_d = StWaitLow;
            end else if (!g_req) begin
               gnt_d   = '0;
               state_d = StIdle;
            end
         end
         StWaitLow: begin
            // Ignore a stale ready-high until the tile has visibly gone busy.
            o_cim_rd_addr = g_addr;
            if (!i_cim_ready) begin
               state_d = StWaitHigh;
            end
         end
         StWaitHigh: begin
            o_cim_rd_addr = g_addr;
            if (i_cim_ready) begin
               gnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         gnt_q     <= '0;
         gnt_idx_q <= IDX_WIDTH'(NUM_REQ - 1);
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
      end
   end

   assign o_gnt           = gnt_q;
   assign o_gnt_idx       = gnt_idx_q;
   assign o_busy          = (state_q != StIdle);
   assign o_req_cim_ready = gnt_q & {NUM_REQ{i_cim_ready}};

endmodule

// File: tb/tb_cim_tile_arbiter.sv
// Randomized job-level bench for cim_tile_arbiter with a queue-based scoreboard
// plus a few directed reset/isolation scenarios.
module tb_cim_tile_arbiter;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned ADDR_WIDTH = 4;
   localparam int unsigned IDX_WIDTH  = $clog2(NUM_REQ);

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    i_req, i_req_we, i_req_start;
   logic [ADDR_WIDTH-1:0] i_req_addr [NUM_REQ-1:0];
   logic [NUM_REQ-1:0]    o_gnt, o_req_cim_ready;
   logic [IDX_WIDTH-1:0]  o_gnt_idx;
   logic                  o_busy, o_cim_we, o_cim_start;
   logic [ADDR_WIDTH-1:0] o_cim_rd_addr;
   logic                  i_cim_ready;

   cim_tile_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ADDR_WIDTH (ADDR_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_req           (i_req),
      .i_req_we        (i_req_we),
      .i_req_start     (i_req_start),
      .i_req_addr      (i_req_addr),
      .o_gnt           (o_gnt),
      .o_req_cim_ready (o_req_cim_ready),
      .o_gnt_idx       (o_gnt_idx),
      .o_busy          (o_busy),
      .o_cim_we        (o_cim_we),
      .o_cim_start     (o_cim_start),
      .o_cim_rd_addr   (o_cim_rd_addr),
      .i_cim_ready     (i_cim_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int we;
   } start_t;

   int     tests  = 0;
   int     fails  = 0;
   bit     mon_en = 1'b0;
   int     last_g = NUM_REQ - 1;
   int     exp_gnt_q[$];
   int     exp_hold_q[$];
   start_t exp_start_q[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Lowest requested index above the last grant, otherwise the lowest requested.
   function automatic int model_pick(input logic [NUM_REQ-1:0] set, input int last);
      int above  = -1;
      int lowest = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (set[i]) begin
            lowest = i;
            if (i > last) above = i;
         end
      end
      return (above >= 0) ? above : lowest;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic noise(input int g);
      for (int i = 0; i < NUM_REQ; i++) i_req_addr[i] = ADDR_WIDTH'($urandom);
      i_req_we       = NUM_REQ'($urandom);
      i_req_start    = NUM_REQ'($urandom);
      i_req_we[g]    = 1'b0;
      i_req_start[g] = 1'b0;
   endtask

   task automatic noise_wait(input int g);
      noise(g);
      i_req_we[g]    = 1'b1;
      i_req_start[g] = 1'($urandom);
   endtask

   // mode 0: full job, 1: drop request with start, 2: drop request alone.
   task automatic run_round(input logic [NUM_REQ-1:0] set, input int mode,
                            input int w, input int k, input int m);
      int     g;
      start_t s;
      g      = model_pick(set, last_g);
      last_g = g;
      exp_gnt_q.push_back(g);
      exp_hold_q.push_back((mode == 0) ? (w + k + m + 2) : (w + 1));
      i_req       = set;
      i_cim_ready = 1'b1;
      noise(g);
      step();
      for (int c = 0; c < w; c++) begin
         noise(g);
         step();
      end
      noise(g);
      if (mode == 0) begin
         s.addr         = int'($urandom_range(0, 2 ** ADDR_WIDTH - 1));
         s.we           = int'($urandom_range(0, 1));
         i_req_start[g] = 1'b1;
         i_req_we[g]    = 1'(s.we);
         i_req_addr[g]  = ADDR_WIDTH'(s.addr);
         exp_start_q.push_back(s);
         step();
         for (int c = 0; c < k; c++) begin
            noise_wait(g);
            step();
         end
         i_cim_ready = 1'b0;
         for (int c = 0; c < m; c++) begin
            noise_wait(g);
            step();
         end
         i_cim_ready = 1'b1;
         noise_wait(g);
         step();
      end else begin
         i_req[g]       = 1'b0;
         i_req_start[g] = (mode == 1);
         step();
      end
   endtask

   initial begin : monitor
      logic [NUM_REQ-1:0] prev_gnt;
      logic [NUM_REQ-1:0] prev_rdy;
      int                 hold;
      int                 e;
      start_t             s;
      prev_gnt = '0;
      prev_rdy = '0;
      hold     = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (o_gnt != '0 && prev_gnt == '0) begin
               hold = 0;
               if (exp_gnt_q.size() == 0) begin
                  check("unexpected_grant", int'(o_gnt), 0);
               end else begin
                  e = exp_gnt_q.pop_front();
                  check("grant_onehot", int'(o_gnt), 1 << e);
                  check("grant_idx", int'(o_gnt_idx), e);
               end
            end
            if (prev_gnt != '0 && o_gnt != '0 && o_gnt != prev_gnt)
               check("grant_idle_gap", int'(o_gnt), 0);
            if (prev_gnt != '0 && o_gnt == '0) begin
               if (exp_hold_q.size() == 0) check("unexpected_release", hold, 0);
               else check("grant_hold_cycles", hold, exp_hold_q.pop_front());
               check("completion_ready", int'(prev_rdy), int'(prev_gnt));
            end
            if (o_gnt != '0) hold++;
            if (o_cim_start) begin
               if (exp_start_q.size() == 0) begin
                  check("unexpected_start", 1, 0);
               end else begin
                  s = exp_start_q.pop_front();
                  check("start_addr", int'(o_cim_rd_addr), s.addr);
                  check("start_we", int'(o_cim_we), s.we);
               end
            end else if (o_cim_we) begin
               check("we_outside_start", 1, 0);
            end
            check("busy_vs_grant", int'(o_busy), int'(o_gnt != '0));
            check("ready_isolation", int'(o_req_cim_ready & ~o_gnt), 0);
         end
         prev_gnt = o_gnt;
         prev_rdy = o_req_cim_ready;
      end
   end

   initial begin : driver
      rst         = 1'b1;
      i_req       = '0;
      i_req_we    = '0;
      i_req_start = '0;
      i_cim_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) i_req_addr[i] = '0;
      #1;
      check("rst_gnt", int'(o_gnt), 0);
      check("rst_gnt_idx", int'(o_gnt_idx), NUM_REQ - 1);
      check("rst_busy", int'(o_busy), 0);
      check("rst_cim_start", int'(o_cim_start), 0);
      check("rst_cim_addr", int'(o_cim_rd_addr), 0);
      step();
      step();
      rst    = 1'b0;
      mon_en = 1'b1;

      // All requesting, 4-cycle jobs: expect 0,1,2,3,0.
      for (int r = 0; r < 5; r++) run_round(4'hF, 0, 0, 0, 2);
      for (int r = 0; r < 60; r++) begin
         int mode;
         mode = int'($urandom_range(0, 3));
         run_round(NUM_REQ'($urandom_range(1, 2 ** NUM_REQ - 1)), (mode < 2) ? 0 : mode - 1,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 3)));
      end
      i_req       = '0;
      i_req_start = '0;
      i_req_we    = '0;
      step();
      step();
      mon_en = 1'b0;
      check("leftover_grants", exp_gnt_q.size(), 0);
      check("leftover_releases", exp_hold_q.size(), 0);
      check("leftover_starts", exp_start_q.size(), 0);

      // Single job, then asynchronous reset in the middle of the compute wait.
      i_req = 4'b0100;
      step();
      check("dir_grant", int'(o_gnt), 4);
      check("dir_gnt_idx", int'(o_gnt_idx), 2);
      i_req_start[2] = 1'b1;
      i_req_addr[2]  = 4'd5;
      #1;
      check("dir_start", int'(o_cim_start), 1);
      check("dir_start_addr", int'(o_cim_rd_addr), 5);
      step();
      i_req_start = 4'b0100;
      i_req_we    = 4'b0100;
      #1;
      check("dir_wait_we_gated", int'(o_cim_we), 0);
      check("dir_wait_start_gated", int'(o_cim_start), 0);
      step();
      check("dir_stale_ready_hold", int'(o_gnt), 4);
      check("dir_stale_ready_busy", int'(o_busy), 1);
      i_cim_ready = 1'b0;
      step();
      check("dir_wait_high_hold", int'(o_gnt), 4);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_gnt", int'(o_gnt), 0);
      check("async_rst_busy", int'(o_busy), 0);
      check("async_rst_start", int'(o_cim_start), 0);
      check("async_rst_we", int'(o_cim_we), 0);
      check("async_rst_addr", int'(o_cim_rd_addr), 0);
      check("async_rst_idx", int'(o_gnt_idx), NUM_REQ - 1);
      step();
      rst         = 1'b0;
      i_req       = 4'b1001;
      i_req_start = '0;
      i_req_we    = '0;
      i_cim_ready = 1'b1;
      step();
      check("post_rst_first_grant", int'(o_gnt), 1);

      // Ungranted requester driving the command lines must not leak through.
      i_req = '0;
      step();
      check("drop_release", int'(o_gnt), 0);
      i_req = 4'b1010;
      step();
      check("iso_grant", int'(o_gnt), 2);
      i_req_we      = 4'b1000;
      i_req_start   = 4'b1000;
      i_req_addr[3] = 4'd9;
      i_req_addr[1] = 4'd6;
      #1;
      check("iso_we", int'(o_cim_we), 0);
      check("iso_start", int'(o_cim_start), 0);
      check("iso_addr", int'(o_cim_rd_addr), 6);
      check("iso_ready3", int'(o_req_cim_ready[3]), 0);
      check("iso_ready1", int'(o_req_cim_ready[1]), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
